// File: rtl/header_tcam_engine_if.sv
// header_tcam_engine_if: groups the table-write, lookup and result signals of
// header_tcam_engine.
//   master : control plane / parser side (drives writes, keys, out_ready)
//   slave  : the engine (drives key_ready and the result bundle)
// Signals:
//   wr_en, wr_addr, wr_value, wr_mask, wr_map, wr_entry_valid : entry write port
//   clr_all                                                    : invalidate all entries
//   key_valid, key, key_ready                                  : lookup request handshake
//   out_valid, out_ready, out_bv, out_hit, out_first           : lookup result handshake
interface header_tcam_engine_if #(
    parameter int unsigned KEY_W   = 72,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned BVSIZE  = 256,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
);
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [KEY_W-1:0]  wr_value;
    logic [KEY_W-1:0]  wr_mask;
    logic [BVSIZE-1:0] wr_map;
    logic              wr_entry_valid;
    logic              clr_all;
    logic              key_valid;
    logic [KEY_W-1:0]  key;
    logic              key_ready;
    logic              out_valid;
    logic              out_ready;
    logic [BVSIZE-1:0] out_bv;
    logic              out_hit;
    logic [IDX_W-1:0]  out_first;

    modport master (
        output wr_en, wr_addr, wr_value, wr_mask, wr_map, wr_entry_valid, clr_all,
        output key_valid, key, out_ready,
        input  key_ready, out_valid, out_bv, out_hit, out_first
    );

    modport slave (
        input  wr_en, wr_addr, wr_value, wr_mask, wr_map, wr_entry_valid, clr_all,
        input  key_valid, key, out_ready,
        output key_ready, out_valid, out_bv, out_hit, out_first
    );
endinterface

// File: rtl/header_tcam_engine.sv
// header_tcam_engine: runtime-programmable ternary match engine. A 72-bit
// {proto, sa, da} key is compared against ENTRIES value/mask/valid entries; the
// rule maps of all hitting entries are ORed into out_bv and the lowest hitting
// index is reported in out_first. Two pipeline registers: S1 holds the hit
// vector, the output stage holds the reduced result.
// Ports:
//   axi_aclk   : clock, rising edge
//   axi_resetn : asynchronous active-low reset
//   bus        : header_tcam_engine_if slave (write port, clr_all, key and
//                result handshakes)
module header_tcam_engine #(
    parameter int unsigned KEY_W   = 72,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned BVSIZE  = 256,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input logic                 axi_aclk,
    input logic                 axi_resetn,
    header_tcam_engine_if.slave bus
);

    // Entry table
    logic [KEY_W-1:0]   value_q [ENTRIES];
    logic [KEY_W-1:0]   mask_q  [ENTRIES];
    logic [BVSIZE-1:0]  map_q   [ENTRIES];
    logic [BVSIZE-1:0]  map_d   [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [ENTRIES-1:0] wr_sel;

    // Pipeline
    logic               live_q;
    logic               s1_valid_q;
    logic [ENTRIES-1:0] s1_hit_q;
    logic               out_valid_q;
    logic [BVSIZE-1:0]  out_bv_q;
    logic               out_hit_q;
    logic [IDX_W-1:0]   out_first_q;

    logic               adv_out;
    logic               adv_s1;
    logic               key_ready;
    logic               key_acc;
    logic [ENTRIES-1:0] hit_c;
    logic [BVSIZE-1:0]  bv_c;
    logic [IDX_W-1:0]   first_c;

    // Out-of-range addresses never match any wr_sel bit, so they are dropped.
    // The clear is applied first, then the write overrides the written entry.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            wr_sel[i]  = bus.wr_en && (bus.wr_addr == IDX_W'(i));
            valid_d[i] = wr_sel[i] ? bus.wr_entry_valid : (valid_q[i] && !bus.clr_all);
            map_d[i]   = wr_sel[i] ? bus.wr_map : map_q[i];
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                value_q[i] <= '0;
                mask_q[i]  <= '0;
                map_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < ENTRIES; i++) begin
                map_q[i] <= map_d[i];
                if (wr_sel[i]) begin
                    value_q[i] <= bus.wr_value;
                    mask_q[i]  <= bus.wr_mask;
                end
            end
        end
    end

    // Handshake control. live_q keeps key_ready low until the first edge after reset.
    always_comb begin
        adv_out   = !out_valid_q || bus.out_ready;
        adv_s1    = !s1_valid_q || adv_out;
        key_ready = live_q && adv_s1 && !bus.wr_en && !bus.clr_all;
        key_acc   = bus.key_valid && key_ready;
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            hit_c[i] = valid_q[i] && (((bus.key ^ value_q[i]) & mask_q[i]) == '0);
        end
    end

    // S2 reduction. Maps are taken from map_d so that a write landing on the
    // same edge that retires the S1 key is reflected in that key's out_bv.
    always_comb begin
        bv_c    = '0;
        first_c = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (s1_hit_q[i]) begin
                bv_c = bv_c | map_d[i];
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (s1_hit_q[i]) begin
                first_c = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            live_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= '0;
            out_valid_q <= 1'b0;
            out_bv_q    <= '0;
            out_hit_q   <= 1'b0;
            out_first_q <= '0;
        end else begin
            live_q <= 1'b1;
            if (adv_s1) begin
                s1_valid_q <= key_acc;
                if (key_acc) begin
                    s1_hit_q <= hit_c;
                end
            end
            if (adv_out) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_bv_q    <= bv_c;
                    out_hit_q   <= |s1_hit_q;
                    out_first_q <= first_c;
                end
            end
        end
    end

    assign bus.key_ready = key_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bv    = out_bv_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_first = out_first_q;

endmodule
